// File: rtl/pipe_hazard_if.sv
// Pipeline hazard control bundle: hazard-detect inputs, dmem handshake, stage enables/flushes, counters.
// master = the hazard controller, slave = the pipeline/memory side.
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_regwrite;
    logic [1:0]       ex_memtoreg;
    logic             ex_br_taken;
    logic             mem_memwrite;
    logic [1:0]       mem_memtoreg;
    logic             dmem_ready;
    logic             dmem_req;
    logic             dmem_we;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_regwrite, ex_memtoreg,
               ex_br_taken, mem_memwrite, mem_memtoreg, dmem_ready,
        output dmem_req, dmem_we, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_regwrite, ex_memtoreg,
               ex_br_taken, mem_memwrite, mem_memtoreg, dmem_ready,
        input  dmem_req, dmem_we, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubble, taken-branch squash,
// whole-pipe freeze while data memory is busy, memory timeout trap and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [1:0]  LOAD_CODE   = 2'b01,
    parameter int          CNT_W       = 16
) (
    input logic           clk,
    input logic           rst,
    pipe_hazard_if.master bus
);

    localparam logic [1:0]  S_RUN  = 2'd0;
    localparam logic [1:0]  S_WAIT = 2'd1;
    localparam logic [1:0]  S_ERR  = 2'd2;
    localparam logic [16:0] TMO    = 17'(MEM_TIMEOUT);

    logic [1:0]       state;
    logic [15:0]      wait_timer;
    logic [16:0]      timer_nxt;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic in_err;
    logic mem_acc;
    logic dmem_req;
    logic freeze;
    logic load_use;
    logic active;
    logic br_eff;
    logic lu_eff;
    logic stall_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign in_err   = (state == S_ERR);
    assign mem_acc  = bus.mem_memwrite | (bus.mem_memtoreg == LOAD_CODE);
    assign dmem_req = mem_acc & ~in_err & ~rst;
    assign freeze   = dmem_req & ~bus.dmem_ready;

    assign load_use = bus.ex_regwrite & (bus.ex_memtoreg == LOAD_CODE) & (bus.ex_rd != 5'd0) &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

    // Only an unfrozen, non-trapped, out-of-reset cycle may advance or squash the pipe.
    assign active    = ~rst & ~in_err & ~freeze;
    assign br_eff    = active & bus.ex_br_taken;
    assign lu_eff    = active & ~bus.ex_br_taken & load_use;
    assign stall_inc = ~rst & ~in_err & (freeze | lu_eff);

    assign timer_nxt = {1'b0, wait_timer} + 17'd1;

    assign bus.dmem_req  = dmem_req;
    assign bus.dmem_we   = bus.mem_memwrite & dmem_req;
    assign bus.mem_err   = in_err;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    always_comb begin
        bus.pc_en       = 1'b0;
        bus.if_id_en    = 1'b0;
        bus.id_ex_en    = 1'b0;
        bus.ex_mem_en   = 1'b0;
        bus.mem_wb_en   = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        if (rst) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (active) begin
            bus.id_ex_en  = 1'b1;
            bus.ex_mem_en = 1'b1;
            bus.mem_wb_en = 1'b1;
            if (bus.ex_br_taken) begin
                bus.pc_en       = 1'b1;
                bus.if_id_en    = 1'b1;
                bus.if_id_flush = 1'b1;
                bus.id_ex_flush = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, insert one bubble into EX.
                bus.id_ex_flush = 1'b1;
            end else begin
                bus.pc_en    = 1'b1;
                bus.if_id_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            wait_timer  <= 16'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (freeze) begin
                        wait_timer <= 16'd1;
                        state      <= (TMO <= 17'd1) ? S_ERR : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // wait_timer counts frozen cycles already spent on this access.
                    if (!freeze) begin
                        state      <= S_RUN;
                        wait_timer <= 16'd0;
                    end else if (timer_nxt >= TMO) begin
                        state <= S_ERR;
                    end else begin
                        wait_timer <= timer_nxt[15:0];
                    end
                end
                default: state <= S_ERR;
            endcase
            if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (br_eff)    flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

endmodule
